// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: CPU-bus memory model with preload port, write-protected ROM
// region, optional registered read, saturating access counters, a sticky
// trap-address detector and a sticky stuck-address (stall) detector.
module cpu_bus_mem #(
    parameter int                 ADDR_W    = 16,
    parameter int                 DATA_W    = 8,
    parameter int                 DEPTH     = 1024,
    parameter int                 ROM_BASE  = 768,
    parameter logic [DATA_W-1:0]  FILL      = DATA_W'(8'hff),
    parameter int                 RD_LAT    = 0,
    parameter logic [ADDR_W-1:0]  TRAP_ADDR = ADDR_W'(16'hfffe),
    parameter int                 STALL_CYC = 16,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_ph1,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  wr_blocked,
    output logic              trap_hit,
    output logic              stall
);

    localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYC - 1);

    // Storage has no reset so a preloaded image survives a CPU reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  rd_count_q,   rd_count_d;
    logic [CNT_W-1:0]  wr_count_q,   wr_count_d;
    logic [CNT_W-1:0]  wr_blocked_q, wr_blocked_d;
    logic              trap_hit_q,   trap_hit_d;
    logic              stall_q,      stall_d;
    logic [CNT_W-1:0]  rep_q,        rep_d;
    logic [ADDR_W-1:0] prev_addr_q,  prev_addr_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;

    logic              addr_in_mem;
    logic              ld_in_mem;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              wr_ok;
    logic              addr_match;
    logic [DATA_W-1:0] rd_comb;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic              en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Decode the bus cycle, select the array write source and form the read
    // value; out-of-range addresses never index the array.
    always_comb begin
        addr_in_mem = 32'(addr) < DEPTH;
        ld_in_mem   = 32'(ld_addr) < DEPTH;
        cpu_wr      = !rw && !ld_en;
        cpu_rd      = rw && !ld_en;
        wr_ok       = cpu_wr && addr_in_mem && (32'(addr) < ROM_BASE);
        rd_comb     = FILL;
        if (addr_in_mem) begin
            rd_comb = mem[addr[IDX_W-1:0]];
        end
        // Preload wins over a CPU write on the same edge; nothing is written
        // while reset is held low.
        mem_we    = rst && ((ld_en && ld_in_mem) || wr_ok);
        mem_widx  = ld_en ? ld_addr[IDX_W-1:0] : addr[IDX_W-1:0];
        mem_wdata = ld_en ? ld_data : wdata;
    end

    // Next-state for counters, sticky flags, stall tracking and read register.
    always_comb begin
        rd_count_d   = sat_inc(rd_count_q, cpu_rd);
        wr_count_d   = sat_inc(wr_count_q, wr_ok);
        wr_blocked_d = sat_inc(wr_blocked_q, cpu_wr && !wr_ok);
        trap_hit_d   = trap_hit_q | (rw && (addr == TRAP_ADDR));
        addr_match   = (addr == prev_addr_q);
        rep_d        = addr_match ? sat_inc(rep_q, 1'b1) : '0;
        stall_d      = stall_q | (addr_match && (rep_d >= STALL_LIM));
        prev_addr_d  = addr;
        rdata_d      = rd_comb;
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            wr_blocked_q <= '0;
            trap_hit_q   <= 1'b0;
            stall_q      <= 1'b0;
            rep_q        <= '0;
            prev_addr_q  <= '0;
            rdata_q      <= FILL;
        end else begin
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
            wr_blocked_q <= wr_blocked_d;
            trap_hit_q   <= trap_hit_d;
            stall_q      <= stall_d;
            rep_q        <= rep_d;
            prev_addr_q  <= prev_addr_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory array write port (preload or accepted CPU write).
    always_ff @(posedge clk_ph1) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Output drive; RD_LAT selects combinational or registered read data.
    always_comb begin
        rdata      = (RD_LAT == 1) ? rdata_q : rd_comb;
        rd_count   = rd_count_q;
        wr_count   = wr_count_q;
        wr_blocked = wr_blocked_q;
        trap_hit   = trap_hit_q;
        stall      = stall_q;
    end

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Directed bench for cpu_bus_mem. Three instances share one stimulus stream:
// combinational read (dut_c), registered read (dut_r), 4-bit counters (dut_s).
module tb_cpu_bus_mem;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    logic [7:0]  c_rdata, r_rdata, s_rdata;
    logic [15:0] c_rd, c_wr, c_blk, r_rd, r_wr, r_blk;
    logic [3:0]  s_rd, s_wr, s_blk;
    logic        c_trap, c_stall, r_trap, r_stall, s_trap, s_stall;

    int checks   = 0;
    int failures = 0;

    cpu_bus_mem #(.RD_LAT(0)) dut_c (
        .clk_ph1(clk_ph1), .rst(rst), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(c_rdata), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_count(c_rd), .wr_count(c_wr), .wr_blocked(c_blk),
        .trap_hit(c_trap), .stall(c_stall)
    );

    cpu_bus_mem #(.RD_LAT(1)) dut_r (
        .clk_ph1(clk_ph1), .rst(rst), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(r_rdata), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_count(r_rd), .wr_count(r_wr), .wr_blocked(r_blk),
        .trap_hit(r_trap), .stall(r_stall)
    );

    cpu_bus_mem #(.RD_LAT(0), .CNT_W(4)) dut_s (
        .clk_ph1(clk_ph1), .rst(rst), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(s_rdata), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_count(s_rd), .wr_count(s_wr), .wr_blocked(s_blk),
        .trap_hit(s_trap), .stall(s_stall)
    );

    // Clock
    initial begin
        clk_ph1 = 1'b0;
        forever #5 clk_ph1 = ~clk_ph1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return 1 time unit after it.
    task automatic step();
        @(posedge clk_ph1);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] d);
        addr  = a;
        rw    = r;
        wdata = d;
        ld_en = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        rw      = 1'b1;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        ld_en = 1'b0;
        rw    = 1'b1;
        addr  = 16'h0000;
        step();
        rst   = 1'b1;
    endtask

    initial begin
        rst = 1'b0; addr = '0; rw = 1'b1; wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        step();
        check("reset_rd_count", c_rd, 0);
        check("reset_wr_count", c_wr, 0);
        check("reset_wr_blocked", c_blk, 0);
        check("reset_flags", {c_trap, c_stall}, 0);
        check("reset_rdata_reg", r_rdata, 8'hff);
        rst = 1'b1;

        // Preload then combinational reads
        preload(16'd0, 8'ha9);
        preload(16'd1, 8'h0f);
        bus(16'd0, 1'b1, 8'h00);
        #1 check("comb_read_0", c_rdata, 8'ha9);
        step();
        check("reg_read_0", r_rdata, 8'ha9);
        bus(16'd1, 1'b1, 8'h00);
        #1 check("comb_read_1", c_rdata, 8'h0f);
        step();
        check("rd_count_2", c_rd, 2);

        // CPU write then registered read-after-write
        do_reset();
        bus(16'd10, 1'b0, 8'h55);
        step();
        bus(16'd10, 1'b1, 8'h00);
        step();
        check("reg_raw_10", r_rdata, 8'h55);
        check("wr_count_1", c_wr, 1);
        bus(16'd2000, 1'b1, 8'h00);
        #1 check("comb_unimpl", c_rdata, 8'hff);
        step();
        check("reg_unimpl", r_rdata, 8'hff);

        // ROM and unimplemented writes are blocked; preload ignores ROM
        do_reset();
        preload(16'd800, 8'h34);
        bus(16'd800, 1'b0, 8'h12);
        step();
        bus(16'd5000, 1'b0, 8'h12);
        step();
        check("wr_blocked_2", c_blk, 2);
        check("wr_count_0", c_wr, 0);
        bus(16'd800, 1'b1, 8'h00);
        #1 check("rom_unchanged", c_rdata, 8'h34);
        preload(16'd800, 8'h12);
        bus(16'd800, 1'b1, 8'h00);
        #1 check("rom_preloaded", c_rdata, 8'h12);

        // Preload beats a simultaneous CPU write
        do_reset();
        addr = 16'd20; wdata = 8'hbb; rw = 1'b0;
        ld_en = 1'b1; ld_addr = 16'd20; ld_data = 8'haa;
        step();
        bus(16'd20, 1'b1, 8'h00);
        #1 check("collide_data", c_rdata, 8'haa);
        check("collide_counts", {c_wr, c_blk}, 0);

        // Stall after 16 edges on one address
        do_reset();
        bus(16'h0101, 1'b1, 8'h00);
        for (int i = 0; i < 15; i++) step();
        check("stall_edge15", c_stall, 0);
        step();
        check("stall_edge16", c_stall, 1);
        bus(16'h0202, 1'b1, 8'h00);
        step();
        check("stall_sticky", c_stall, 1);

        // Address change at edge 15 avoids stall
        do_reset();
        bus(16'h0101, 1'b1, 8'h00);
        for (int i = 0; i < 14; i++) step();
        bus(16'h0202, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step();
        check("no_stall", c_stall, 0);

        // Trap detector
        check("trap_before", c_trap, 0);
        bus(16'hfffe, 1'b1, 8'h00);
        step();
        check("trap_set", c_trap, 1);
        bus(16'h0003, 1'b1, 8'h00);
        step();
        check("trap_sticky", c_trap, 1);

        // Asynchronous reset mid-sequence, including a suppressed write
        do_reset();
        preload(16'd31, 8'h11);
        bus(16'd30, 1'b0, 8'h77);
        step();
        bus(16'd900, 1'b0, 8'h77);
        step();
        bus(16'hfffe, 1'b1, 8'h00);
        step();
        check("pre_rst_counts", {c_rd, c_wr, c_blk}, {16'd1, 16'd1, 16'd1});
        check("pre_rst_trap", c_trap, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_counts", {c_rd, c_wr, c_blk}, 0);
        check("async_rst_flags", {c_trap, c_stall, r_trap}, 0);
        check("async_rst_rdata", r_rdata, 8'hff);
        bus(16'd31, 1'b0, 8'h66);
        step();
        rst = 1'b1;
        bus(16'd31, 1'b1, 8'h00);
        #1 check("write_in_rst_dropped", c_rdata, 8'h11);
        step();
        check("rd_after_release", c_rd, 1);
        bus(16'd30, 1'b1, 8'h00);
        #1 check("ram_survives_rst", c_rdata, 8'h77);
        bus(16'd0, 1'b1, 8'h00);
        #1 check("preload_survives_rst", c_rdata, 8'ha9);

        // Counter saturation with 4-bit counters
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus(16'(i + 100), 1'b1, 8'h00);
            step();
        end
        check("sat_rd_count", s_rd, 4'hf);
        check("wide_rd_count", c_rd, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_bus_mem.md
Name: cpu_bus_mem

Overview:
- Parametrised memory and bus model that sits on the CPU address/data bus, in place of a fixed hard-coded program table.
- Supports preload of program images, CPU writes with a write-protected ROM region, and optional registered reads.
- Provides access counters, a trap-address detector and a stuck-bus detector so benches can end runs and check progress automatically.

Parameters:
- ADDR_W, 16, CPU address width.
- DATA_W, 8, data width.
- DEPTH, 1024, number of implemented words at addresses 0..DEPTH-1.
- ROM_BASE, 768, first write-protected address. The ROM region is ROM_BASE..DEPTH-1. ROM_BASE >= DEPTH disables protection.
- FILL, 8'hff, read value for unimplemented addresses.
- RD_LAT, 0, read latency: 0 = combinational, 1 = registered.
- TRAP_ADDR, 16'hfffe, address whose read raises trap_hit.
- STALL_CYC, 16, number of consecutive identical-address cycles that raises stall.
- CNT_W, 16, counter width.

Ports:
- clk_ph1  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  CPU address bus.
- rw  in  1  1 = read, 0 = write.
- wdata  in  DATA_W  CPU write data.
- rdata  out  DATA_W  read data to CPU.
- ld_en  in  1  preload strobe.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.
- rd_count  out  CNT_W  completed reads.
- wr_count  out  CNT_W  accepted CPU writes.
- wr_blocked  out  CNT_W  CPU writes rejected (ROM region or unimplemented address).
- trap_hit  out  1  sticky; set on a read of TRAP_ADDR.
- stall  out  1  sticky; set when the stuck-address condition is met.

Behaviour:
- Memory array: DEPTH x DATA_W. Contents are not cleared by rst, so a preload survives CPU reset.
- Read data, RD_LAT=0: rdata = mem[addr] if addr < DEPTH, else FILL. Purely combinational.
- Read data, RD_LAT=1: rdata is registered each edge from the same expression.
  - Reset value FILL.
  - A read-after-write to the same address returns the new data one edge after the write edge.
- Preload: on an edge with ld_en=1 and ld_addr < DEPTH, mem[ld_addr] <= ld_data. ROM protection is ignored. ld_addr >= DEPTH is dropped silently and not counted.
- CPU write: on an edge with rw=0 and ld_en=0:
  - Accepted when addr < DEPTH and addr < ROM_BASE: mem[addr] <= wdata, wr_count++.
  - Otherwise: memory unchanged, wr_blocked++.
- Simultaneous ld_en=1 and rw=0: preload wins and the CPU write is discarded. Neither wr_count nor wr_blocked changes.
- rd_count increments on every edge with rw=1 and ld_en=0, including reads of unimplemented addresses.
- All counters saturate at all-ones. They do not wrap.
- trap_hit is set on an edge with rw=1 and addr == TRAP_ADDR. It holds until rst.
- Stall detector:
  - prev_addr register, reset 0. rep counter of CNT_W bits, reset 0.
  - Each edge: if addr == prev_addr, rep <= rep+1 (saturating); else rep <= 0. Then prev_addr <= addr.
  - stall is set when rep reaches STALL_CYC-1 and addr == prev_addr on that edge, i.e. STALL_CYC consecutive edges sampling the same address. It is sticky until rst.
  - The first edge after reset compares against prev_addr=0.
- Reset, asserted asynchronously at any time, including mid-write: all outputs and registers go to their reset values immediately.
  - Counters 0, trap_hit 0, stall 0, rep 0, prev_addr 0, rdata FILL when RD_LAT=1.
  - A write on an edge coincident with rst=0 does not occur.
- Reset release: behaviour resumes at the first rising edge with rst=1.
- No X propagation: unimplemented addresses never index the array.

Test Plan:
- Preload 8'ha9 to 0 and 8'h0f to 1, then read 0 and 1 with RD_LAT=0 -> rdata 8'ha9 then 8'h0f in the same cycle; rd_count=2.
- CPU write 8'h55 to address 10, then read 10 with RD_LAT=1 -> rdata 8'h55 one edge after the read edge; wr_count=1. Read address 2000 -> rdata 8'hff.
- CPU write 8'h12 to address 800 (ROM region) and to 5000 -> memory unchanged, wr_blocked=2, wr_count=0. Preload 8'h12 to 800 -> reading 800 returns 8'h12.
- Same edge ld_en=1 (ld_addr=20, ld_data=8'haa) and CPU write addr=20, wdata=8'hbb -> mem[20]=8'haa; wr_count and wr_blocked unchanged.
- Hold addr=16'h0101 with rw=1 for 16 edges -> stall rises on the 16th edge. Change addr at edge 15 instead -> stall stays 0. Read 16'hfffe -> trap_hit=1 and sticky.
- Assert rst mid-sequence with counters nonzero -> all counters, stall and trap_hit go to 0 immediately; preloaded data still reads back after release.
- Build CNT_W=4 and perform 20 reads -> rd_count saturates at 4'hf.
